bitcount_scheduler: RTL
=======================

// Module: bitcount_scheduler
// PURPOSE
//  Shares one bitcount engine (shift register A, counter B, S1/S2/S3 FSM) between N requesters.
//  Per job: round-robin pick, capture operand, load and start engine, wait Done, return B to winner, release engine.
//  Sits between client FSMs and the engine; drives the engine's LA/s/Data and reads its B/Done.
// PARAMETERS
//  N        4    number of requesters (2..8)
//  W        8    operand width, equals engine Data width
//  CW       4    count width, equals engine B width (>= clog2(W+1))
//  TIMEOUT  32   max RUN cycles before abort; must exceed W+4
// PORTS
//  Clock        in   1     rising-edge clock, shared with engine
//  Resetn       in   1     asynchronous, active-low reset
//  req          in   N     req[i]=1: requester i wants a count; held until ack[i]
//  req_data     in   N*W   operand of requester i at [i*W +: W]
//  ack          out  N     one-cycle one-hot pulse: result valid for that requester
//  result       out  CW    popcount; valid only while ack!=0, else 0
//  busy         out  1     1 in any state except IDLE
//  timeout_err  out  1     one-cycle pulse with ack when job aborted; result=0
//  LA           out  1     engine load-A strobe
//  s            out  1     engine start
//  Data         out  W     engine operand (held register, not combinational from req_data)
//  B            in   CW    engine count
//  Done         in   1     engine done (high in engine S3 until s falls)
// BEHAVIOUR
//  Reset (async, Resetn=0): state=IDLE, rr pointer=0, ack=0, result=0, timeout_err=0, LA=0, s=0, Data=0, busy=0.
//  All outputs registered or decoded from registered state; no comb path req->LA/s.
//  IDLE:  if |req: grant = first set bit at or after pointer (wrapping); latch grant idx, Data<=req_data[idx]; ->LOAD.
//  LOAD:  LA=1, s=0 for exactly one cycle (engine in S1: A loaded, B cleared by LB); ->RUN.
//  RUN:   s=1, LA=0; wdog counts up from 0. Done=1 -> latch B into result reg, ->RESP.
//         wdog==TIMEOUT-1 with Done=0 -> ->RESP with err flag set, result=0.
//  RESP:  ack[idx]=1, result valid, timeout_err=err, s=0, one cycle; pointer<=idx+1 (mod N); ->DRAIN.
//  DRAIN: s=0; wait Done=0 (engine back in S1) -> IDLE. Next grant no earlier than cycle after DRAIN.
//  Latency: req seen in IDLE -> ack = 1(IDLE) + 1(LOAD) + engine run (1 + popcount-independent shift count
//           until A==0, <= W) + 1(RESP); operand 0x00 completes in minimum time.
//  Fairness: pointer advances past the served requester only; any requester served within N jobs.
//  req dropped before ack: job still completes; ack still pulses (client ignores). req_data changes after grant ignored.
//  Simultaneous: req rising in same cycle as RESP for another requester is eligible on next IDLE pass.
//  Done high while in IDLE/LOAD (engine not released): stay in IDLE (no grant) until Done=0.
//  Reset mid-job: immediate abort, no ack; engine reset by same Resetn.
// STRUCTURE
//  Shared header bitcount_defs.vh: state encodings (IDLE,LOAD,RUN,RESP,DRAIN, 3-bit), default W/CW.
//  Sub-module rr_arbiter (N): inputs req, pointer; outputs one-hot grant and binary idx; pure comb.
//  Top: state register, idx/pointer/Data/result registers, wdog counter (clog2(TIMEOUT) bits), output decode.
//  Bench instantiates real bitcount engine plus shiftrne to close the loop.
// TESTING
//  Single req[0], data 8'hB5 -> LOAD one cycle, ack=4'b0001 with result=5, busy drops after DRAIN.
//  req=4'b1111, data 8'hFF,8'h00,8'h81,8'h0F (idx0..3) held -> acks in order 0,1,2,3; results 8,0,2,4.
//  Pointer=2 after serving 1, req=4'b0011 -> grant 0 (wrap), then 1.
//  Engine Done stuck 0 -> timeout_err and ack pulse together TIMEOUT cycles after RUN entry, result=0.
//  Resetn low during RUN -> all outputs 0 asynchronously, no ack; after release, pending req served from idx 0.
//  Done forced 1 during IDLE with req=4'b0001 -> no LA until Done=0, then normal job, result correct.

Source files
------------

// File: rtl/bitcount_scheduler_pkg.sv
// bitcount_scheduler_pkg: shared state encoding, defaults and pointer helper
package bitcount_scheduler_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_t;
    localparam int DEF_N       = 4;
    localparam int DEF_W       = 8;
    localparam int DEF_CW      = 4;
    localparam int DEF_TIMEOUT = 32;
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1) % n;
    endfunction
endpackage

// File: rtl/bitcount_scheduler_if.sv
// bitcount_scheduler_if: requester-side request/ack bundle of the scheduler
interface bitcount_scheduler_if
    import bitcount_scheduler_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) ();
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   ack;
    logic [CW-1:0]  result;
    logic           busy;
    logic           timeout_err;
    modport master (output req, req_data, input ack, result, busy, timeout_err);
    modport slave  (input req, req_data, output ack, result, busy, timeout_err);
endinterface

// File: rtl/bitcount_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter
    import bitcount_scheduler_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic found;
    int   p;
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        p     = 0;
        for (int i = 0; i < N; i++) begin
            p = (int'(ptr) + i) % N;
            if (!found && req[p]) begin
                found    = 1'b1;
                grant[p] = 1'b1;
                idx      = IW'(p);
            end
        end
    end
endmodule

// File: rtl/bitcount_scheduler.sv
// bitcount_scheduler: time-shares one bitcount engine among N round-robin requesters
module bitcount_scheduler
    import bitcount_scheduler_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int W       = DEF_W,
    parameter int CW      = DEF_CW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    bitcount_scheduler_if.slave  bus,
    output logic                 LA,
    output logic                 s,
    output logic [W-1:0]         Data,
    input  logic [CW-1:0]        B,
    input  logic                 Done
);
    localparam int IW  = $clog2(N);
    localparam int WDW = $clog2(TIMEOUT);
    state_t          state, state_n;
    logic [IW-1:0]   ptr, idx, gidx;
    logic [N-1:0]    grant, gnt;
    logic [CW-1:0]   res;
    logic            err, expired;
    logic [WDW-1:0]  wdog;
    rr_arbiter #(.N(N), .IW(IW)) u_arb (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx)
    );
    assign expired = wdog == WDW'(TIMEOUT - 1);
    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) state <= IDLE;
        else         state <= state_n;
    // A still-asserted Done means the engine has not returned to S1, so no new grant.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (|bus.req && !Done) ? LOAD : IDLE;
            LOAD:    state_n = RUN;
            RUN:     state_n = (Done || expired) ? RESP : RUN;
            RESP:    state_n = DRAIN;
            DRAIN:   state_n = Done ? DRAIN : IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) begin
            ptr  <= '0;
            idx  <= '0;
            gnt  <= '0;
            Data <= '0;
            res  <= '0;
            err  <= 1'b0;
            wdog <= '0;
        end else begin
            if (state == IDLE && state_n == LOAD) begin
                idx  <= gidx;
                gnt  <= grant;
                Data <= bus.req_data[int'(gidx)*W +: W];
            end
            if (state == LOAD) begin
                wdog <= '0;
                err  <= 1'b0;
            end
            if (state == RUN) begin
                wdog <= wdog + 1'b1;
                res  <= Done ? B : '0;
                err  <= !Done && expired;
            end
            if (state == RESP) ptr <= IW'(wrap_inc(int'(idx), N));
        end
    assign LA              = state == LOAD;
    assign s               = state == RUN;
    assign bus.busy        = state != IDLE;
    assign bus.ack         = state == RESP ? gnt : '0;
    assign bus.result      = state == RESP ? res : '0;
    assign bus.timeout_err = state == RESP && err;
endmodule
